iter_shifter: RTL

- Multicycle, parametrised successor to the datapath's single-cycle combinational shifter.
- Takes an operand, a shift amount and a 2-bit op (SLL/SRL/SRA/ROTR) on a start pulse.
- Shifts up to STEP bits per cycle in an internal register, then pulses done with a registered result and carry-out.
- Sits beside the ALU and is sequenced by the multicycle control FSM through start/busy/done.

---
 rtl/iter_shifter_pkg.sv | 17 +
 rtl/iter_shifter_if.sv | 24 ++
 rtl/iter_shifter_shift_step.sv | 45 ++++
 rtl/iter_shifter.sv | 119 +++++++++++
 4 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the multicycle shifter: operation codes and FSM states.
package iter_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle between the control FSM (master) and the shifter (slave).
interface iter_shifter_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) ();
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               carry;

  modport master (
    output start, op, din, shamt,
    input  busy, done, result, carry
  );

  modport slave (
    input  start, op, din, shamt,
    output busy, done, result, carry
  );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// Combinational single step: shifts/rotates a vector by k positions and reports the last bit out.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 1
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] din,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  // One guard bit beside the vector catches the last bit shifted out.
  logic [WIDTH:0] wide;

  always_comb begin
    wide = '0;
    dout = din;
    cout = 1'b0;
    unique case (op)
      OP_SLL: begin
        wide = {1'b0, din} << k;
        dout = wide[WIDTH-1:0];
        cout = wide[WIDTH];
      end
      OP_SRL: begin
        wide = {din, 1'b0} >> k;
        dout = wide[WIDTH:1];
        cout = wide[0];
      end
      OP_SRA: begin
        wide = $signed({din, 1'b0}) >>> k;
        dout = wide[WIDTH:1];
        cout = wide[0];
      end
      OP_ROTR: begin
        dout = (din >> k) | (din << (WIDTH - int'(k)));
        cout = dout[WIDTH-1];
      end
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multicycle shifter: accepts an operation on start, shifts up to STEP bits per cycle, pulses done.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input logic         clk,
  input logic         rst,
  iter_shifter_if.slave bus
);

  localparam int KW = $clog2(STEP + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;

  logic [SHAMT_W-1:0] eff;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_out;
  logic               step_cout;

  // Shifts clamp at WIDTH; rotations wrap modulo WIDTH.
  always_comb begin
    eff = bus.shamt;
    if (op_e'(bus.op) == OP_ROTR) begin
      eff = SHAMT_W'(int'(bus.shamt) % WIDTH);
    end else if (int'(bus.shamt) > WIDTH) begin
      eff = SHAMT_W'(WIDTH);
    end
  end

  always_comb begin
    k = KW'(rem_q);
    if (int'(rem_q) > STEP) begin
      k = KW'(STEP);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .op   (op_q),
    .din  (work_q),
    .k    (k),
    .dout (step_out),
    .cout (step_cout)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    carry_d  = carry_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = op_e'(bus.op);
          work_d = bus.din;
          rem_d  = eff;
          if (eff == '0) begin
            state_d  = DONE;
            result_d = bus.din;
            carry_d  = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_out;
        rem_d  = rem_q - SHAMT_W'(k);
        if (rem_d == '0) begin
          state_d  = DONE;
          result_d = step_out;
          carry_d  = step_cout;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.carry  = carry_q;

endmodule
